// File: rtl/uxa_ps2_pkg.sv
// Shared types and constants for the UXA PS/2 receive path.
package uxa_ps2_pkg;

  localparam int PS2_DATA_W     = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_weight(input logic [PS2_DATA_W:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uxa_ps2_fifo.sv
// Small FWFT FIFO with registered head, 1-cycle push/pop; push is refused when full
// unless a pop frees the slot in the same cycle.
module uxa_ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] head;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + AW'(1);
  assign level   = cnt;
  assign dat     = head;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      // Head is reloaded from the next slot, or bypassed from the write when that slot is the one arriving.
      if (pop_ok) begin
        if (cnt > (AW+1)'(1)) head <= mem[rd_nxt];
        else if (push_ok)     head <= push_dat;
      end else if (push_ok && empty) begin
        head <= push_dat;
      end
    end
  end

endmodule

// File: rtl/uxa_ps2_rx_fifo.sv
// PS/2 frame receiver into a FIFO; byte pushed one cycle after the stop-bit edge is seen, SYNC_STAGES+1 cycles input latency.
// Valid/ready toward the host; a good frame with the FIFO full is dropped and sets overflow. Parity check: UXA_PS2_PARITY_CHECK_EN.
module uxa_ps2_rx_fifo
  import uxa_ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic                    sys_clk_i,
  input  logic                    reset_ni,
  input  logic                    ps2_c_i,
  input  logic                    ps2_d_i,
  output logic [PS2_DATA_W-1:0]   d_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    frame_err_o,
  output logic                    overflow_o,
  input  logic                    clr_ovf_i,
  output logic [$clog2(DEPTH):0]  level_o
);

`ifdef UXA_PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   c_prev;
  logic                   fall;
  logic                   bit_val;

  ps2_state_t             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_W-1:0]  shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          to_cnt_q;
  logic                   timeout;
  logic                   frame_good;
  logic                   frame_bad;

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;

  assign fall    = c_prev && !c_sync[SYNC_STAGES-1];
  assign bit_val = d_sync[SYNC_STAGES-1];
  assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], ps2_c_i};
      d_sync <= {d_sync[SYNC_STAGES-2:0], ps2_d_i};
      c_prev <= c_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!bit_val) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_bad = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {bit_val, shift_q[PS2_DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_val;
          state_d = STOP;
        end
        STOP: begin
          if (bit_val && (!PAR_EN || odd_weight({par_q, shift_q}))) frame_good = 1'b1;
          else                                                     frame_bad  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      frame_err_o <= frame_bad;
      if (fall || state_q == IDLE) to_cnt_q <= '0;
      else                         to_cnt_q <= to_cnt_q + TW'(1);
      // Clearing wins over a same-cycle drop.
      if (clr_ovf_i)                      overflow_o <= 1'b0;
      else if (frame_good && full && !pop) overflow_o <= 1'b1;
    end
  end

  assign push    = frame_good;
  assign pop     = valid_o && ready_i;
  assign valid_o = !empty;

  uxa_ps2_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PS2_DATA_W)
  ) u_fifo (
    .clk      (sys_clk_i),
    .rst_n    (reset_ni),
    .push     (push),
    .push_dat (shift_q),
    .pop      (pop),
    .dat      (d_o),
    .full     (full),
    .empty    (empty),
    .level    (level_o)
  );

endmodule

// File: tb/tb_uxa_ps2_rx_fifo.sv
// Bench for uxa_ps2_rx_fifo: PS/2 frame stimulus, scoreboard of expected popped bytes.
module tb_uxa_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int TO    = 200;
  localparam int HALF  = 20;

`ifdef UXA_PS2_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_c = 1'b1;
  logic       ps2_d = 1'b1;
  logic [7:0] d_o;
  logic       valid_o;
  logic       ready = 1'b0;
  logic       frame_err;
  logic       ovf;
  logic       clr_ovf = 1'b0;
  logic [3:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  logic [7:0] sb[$];

  uxa_ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) dut (
    .sys_clk_i   (clk),
    .reset_ni    (rst_n),
    .ps2_c_i     (ps2_c),
    .ps2_d_i     (ps2_d),
    .d_o         (d_o),
    .valid_o     (valid_o),
    .ready_i     (ready),
    .frame_err_o (frame_err),
    .overflow_o  (ovf),
    .clr_ovf_i   (clr_ovf),
    .level_o     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (rst_n && valid_o && ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", d_o);
      end else begin
        chk("pop_data", int'(d_o), int'(sb.pop_front()));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input bit b);
    ps2_d = b;
    wait_clk(HALF);
    ps2_c = 1'b0;
    wait_clk(HALF);
    ps2_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] dat, input bit par_flip, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^dat) ^ par_flip, dat, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_d = 1'b1;
  endtask

  task automatic drain(input string tag);
    ready = 1'b1;
    for (int i = 0; i < 200 && level != 0; i++) wait_clk(1);
    wait_clk(2);
    chk({tag, "_drain_level"}, int'(level), 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  typedef struct {
    logic [7:0] dat;
    bit         bad_start;
    bit         par_flip;
    bit         stop;
    bit         exp_err;
    bit         exp_push;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    tbl[0] = '{8'h64, 1'b0, 1'b1, 1'b1, PEN,  !PEN};
    tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    wait_clk(3);
    chk("rst_d_o", int'(d_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_level", int'(level), 0);
    rst_n = 1'b1;
    wait_clk(3);

    // Good frame held in the FIFO with no consumer.
    e0 = err_cnt;
    send_frame(8'h64, 1'b0, 1'b1, 11);
    wait_clk(5);
    chk("f64_valid", int'(valid_o), 1);
    chk("f64_d_o", int'(d_o), 'h64);
    chk("f64_level", int'(level), 1);
    chk("f64_err", err_cnt - e0, 0);
    sb.push_back(8'h64);
    drain("f64");

    foreach (tbl[i]) begin
      e0 = err_cnt;
      if (tbl[i].exp_push) sb.push_back(tbl[i].dat);
      if (tbl[i].bad_start) ps2_bit(1'b1);
      else send_frame(tbl[i].dat, tbl[i].par_flip, tbl[i].stop, 11);
      ps2_d = 1'b1;
      wait_clk(6);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, int'(tbl[i].exp_err));
      drain($sformatf("vec%0d", i));
    end

    // Partial frame abandoned past the timeout, then a clean frame.
    e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b1, 5);
    wait_clk(2 * TO);
    sb.push_back(8'hAA);
    send_frame(8'hAA, 1'b0, 1'b1, 11);
    wait_clk(6);
    chk("timeout_err", err_cnt - e0, 0);
    drain("timeout");

    // Overflow: DEPTH+1 frames with no consumer.
    ready = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      if (k <= DEPTH) sb.push_back(8'(k));
      send_frame(8'(k), 1'b0, 1'b1, 11);
      wait_clk(4);
      if (k == DEPTH) begin
        chk("ovf_full_level", int'(level), DEPTH);
        chk("ovf_before", int'(ovf), 0);
      end
    end
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_level", int'(level), DEPTH);
    chk("ovf_head", int'(d_o), 1);
    clr_ovf = 1'b1;
    wait_clk(1);
    clr_ovf = 1'b0;
    wait_clk(1);
    chk("ovf_clr", int'(ovf), 0);
    drain("ovf");

    // Push of the ninth byte lands in the same cycle as a pop while full.
    ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      sb.push_back(8'h11 + 8'(k));
      send_frame(8'h11 + 8'(k), 1'b0, 1'b1, 11);
    end
    wait_clk(4);
    chk("simul_full_level", int'(level), DEPTH);
    send_frame(8'h19, 1'b0, 1'b1, 10);
    sb.push_back(8'h19);
    ps2_d = 1'b1;
    wait_clk(HALF);
    ps2_c = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    wait_clk(HALF);
    ps2_c = 1'b1;
    wait_clk(4);
    chk("simul_ovf", int'(ovf), 0);
    chk("simul_level", int'(level), DEPTH);
    chk("simul_head", int'(d_o), 'h12);
    drain("simul");

    // Reset in the middle of a frame with a byte already queued.
    ready = 1'b0;
    sb.push_back(8'h33);
    send_frame(8'h33, 1'b0, 1'b1, 11);
    wait_clk(4);
    chk("prerst_valid", int'(valid_o), 1);
    send_frame(8'h77, 1'b0, 1'b1, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_d_o", int'(d_o), 0);
    chk("midrst_err", int'(frame_err), 0);
    chk("midrst_ovf", int'(ovf), 0);
    sb.delete();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    e0 = err_cnt;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    wait_clk(4);
    chk("post_rst_head", int'(d_o), 'h5A);
    chk("post_rst_err", err_cnt - e0, 0);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uxa_ps2_rx_fifo.md
# uxa_ps2_rx_fifo

Parametrised PS/2 receive front end for the UXA keyboard/mouse path. It synchronises the raw PS/2 clock and data lines and deserialises complete 11-bit frames: start, 8 data bits LSB-first, odd parity, stop. Validated bytes are buffered in a small FIFO with a valid/ready handshake toward the host bus interface. It adds inter-bit timeout recovery, error reporting and overflow detection on top of a plain shift register.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2–64.
- `SYNC_STAGES`, 2: flip-flops in each input synchroniser; minimum 2.
- `TIMEOUT_CYC`, 2500: `sys_clk_i` cycles without a PS/2 falling edge before a partial frame is discarded (≈200 µs at 12.5 MHz).
- `sys_clk_i`  in  1  system clock; the only clock.
- `reset_ni`  in  1  reset, asynchronous assert, active-low.
- `ps2_c_i`  in  1  raw PS/2 clock; asynchronous.
- `ps2_d_i`  in  1  raw PS/2 data; asynchronous.
- `d_o`  out  8  FIFO head byte; valid only while `valid_o`=1.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer accepts `d_o` when `valid_o & ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: bad start, stop or parity bit.
- `overflow_o`  out  1  sticky flag: a good frame arrived with the FIFO full.
- `clr_ovf_i`  in  1  clears `overflow_o`.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Both PS/2 lines pass through `SYNC_STAGES` flip-flops, which reset to 1. A falling edge is a synced clock of 1→0 between consecutive cycles.
- Receiver FSM states:
  - IDLE: on a falling edge with data=0 go to DATA with bit count 0. A falling edge with data=1 is a bad start: pulse `frame_err_o` and stay in IDLE.
  - DATA: each falling edge shifts data into bit 7, shifting right. After the 8th bit go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: on the falling edge the frame is good if stop=1 and the parity check passes. Good frame: push to the FIFO, or set `overflow_o` and drop the byte if the FIFO is full. Bad frame: pulse `frame_err_o`. Either way return to IDLE.
- Timeout counter: reloads on every falling edge and counts only outside IDLE. On expiry it forces IDLE with no error pulse and no push.
- FIFO: pop when `valid_o & ready_i`. A push and a pop in the same cycle are both honoured; this is legal when full, where the pop frees the slot first and the byte is not dropped. `d_o` is the head entry, registered and first-word-fall-through.
- `clr_ovf_i` has priority over a same-cycle overflow set.
- Reset values: FSM=IDLE, `d_o`=0x00, `valid_o`=0, `frame_err_o`=0, `overflow_o`=0, `level_o`=0, FIFO pointers=0.
- Reset mid-frame discards the partial byte. Reset never leaves the FIFO partially filled.

## Timing
- Input to internal edge: `SYNC_STAGES`+1 cycles.
- From the stop-bit falling edge being detected internally:
  - FIFO write on the next clock edge; `valid_o`/`level_o` update 1 cycle later.
  - `frame_err_o` has the same latency as the FIFO write.
- Pop: `d_o` shows the next entry and `level_o` decrements on the clock edge after the handshake.
- Minimum PS/2 bit period supported: 4×(`SYNC_STAGES`+2) cycles.

## Configuration
- `UXA_PS2_PARITY_CHECK_EN` defined: a frame is good only if data XOR parity has odd weight; otherwise `frame_err_o` pulses and the byte is dropped.
- Undefined: the parity bit is sampled and ignored; start/stop checks remain.

## Structure
- Shared package `uxa_ps2_pkg`: FSM state enum (IDLE, DATA, PARITY, STOP), `PS2_DATA_W`=8, `PS2_FRAME_BITS`=11.
- One sub-module, `uxa_ps2_fifo`, parametrised by DEPTH and width. It provides push/pop/full/empty/level; the top level holds the synchronisers, FSM and timeout logic.

## Test plan
- Frame 0x64 (d7..d0 = 0110_0100), parity 0, stop 1, 50 µs half-periods, `ready_i`=0 → `valid_o`=1, `d_o`=0x64, `level_o`=1, no `frame_err_o`.
- Same frame with parity 1, macro defined → one `frame_err_o` pulse, `valid_o` stays 0. Macro undefined → `d_o`=0x64 accepted.
- Abort after 4 data bits for > `TIMEOUT_CYC`, then a clean frame 0xAA (parity 1) → only 0xAA queued, no error pulse.
- DEPTH+1 frames 0x01..0x09 with `ready_i`=0, DEPTH=8 → `level_o`=8, `overflow_o`=1, head 0x01. Draining pops 0x01–0x08 in order. `clr_ovf_i` clears the flag.
- Push of the 9th frame in the same cycle as a pop with the FIFO full → no overflow, `level_o` stays 8, 0x09 present at the tail.
- `reset_ni` asserted mid-DATA → all outputs return to reset values immediately. A subsequent clean frame 0x5A is received correctly.
